// File: rtl/pe0_twiddle_mul_pkg.sv
// Shared constants and types for the PE0 twiddle-multiply stage.
package pe0_twiddle_mul_pkg;

  localparam int DATA_WIDTH = 12;
  localparam int Q          = 3329;
  localparam int BARRETT_K  = 24;
  localparam int BARRETT_M  = 5039;
  localparam int M_WIDTH    = 13;
  localparam int LATENCY    = 4;

  // Product width and reduced-remainder width (r lies in [0, 2Q)).
  localparam int P_WIDTH = 2 * DATA_WIDTH;
  localparam int R_WIDTH = DATA_WIDTH + 1;

  // Width of the p*BARRETT_M register.
  function automatic int pm_width(input int dw);
    return 2 * dw + M_WIDTH;
  endfunction

  localparam int PM_WIDTH = pm_width(DATA_WIDTH);

  // Side-band fields that travel alongside the multiplier.
  typedef struct packed {
    logic                  valid;
    logic                  sel;
    logic [DATA_WIDTH-1:0] u;
    logic [DATA_WIDTH-1:0] v;
  } lane_t;

endpackage

// File: rtl/pe0_twiddle_mul_barrett_reduce.sv
// Three-stage Barrett reduction of a 24-bit product modulo Q, with a
// bypass value muxed into the final register for inverse mode.
module barrett_reduce
  import pe0_twiddle_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [P_WIDTH-1:0]    p,
  input  logic                  bypass,
  input  logic [DATA_WIDTH-1:0] bypass_val,
  output logic [DATA_WIDTH-1:0] res
);

  localparam logic [PM_WIDTH-1:0] M_PM = PM_WIDTH'(BARRETT_M);
  localparam logic [P_WIDTH-1:0]  Q_P  = P_WIDTH'(Q);
  localparam logic [R_WIDTH-1:0]  Q_R  = R_WIDTH'(Q);

  logic [PM_WIDTH-1:0]   pm_next, pm_reg;
  logic [P_WIDTH-1:0]    p2_reg;
  logic [R_WIDTH-1:0]    t;
  logic [P_WIDTH-1:0]    tq;
  logic [R_WIDTH-1:0]    r_next, r_reg;
  logic [DATA_WIDTH-1:0] res_next, res_reg;

  // Quotient estimate numerator p*M.
  always_comb begin
    pm_next = PM_WIDTH'(p) * M_PM;
  end

  // Stage 2: hold pm together with the original product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_reg <= '0;
      p2_reg <= '0;
    end else if (en) begin
      pm_reg <= pm_next;
      p2_reg <= p;
    end
  end

  // Remainder r = p - floor(pm / 2^K) * Q; the estimate is at most one
  // short, so r fits in R_WIDTH bits and the low bits are exact.
  always_comb begin
    t      = R_WIDTH'(pm_reg >> BARRETT_K);
    tq     = P_WIDTH'(t) * Q_P;
    r_next = R_WIDTH'(p2_reg - tq);
  end

  // Stage 3: register the partially reduced remainder.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_reg <= '0;
    else if (en) r_reg <= r_next;
  end

  // Final correction into [0, Q), or pass the bypass value through.
  always_comb begin
    if (bypass)          res_next = bypass_val;
    else if (r_reg >= Q_R) res_next = DATA_WIDTH'(r_reg - Q_R);
    else                 res_next = DATA_WIDTH'(r_reg);
  end

  // Stage 4: output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) res_reg <= '0;
    else if (en) res_reg <= res_next;
  end

  assign res = res_reg;

endmodule

// File: rtl/pe0_twiddle_mul_delay.sv
// Enabled shift register of configurable depth, one register per stage.
module pe0_twiddle_mul_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] q_reg;
      logic [WIDTH-1:0] d;

      if (gi == 0) begin : g_first
        assign d = din;
      end else begin : g_next
        assign d = g_stage[gi-1].q_reg;
      end

      // Stage register: clears on reset, shifts only when enabled.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) q_reg <= '0;
        else if (en) q_reg <= d;
      end
    end
  endgenerate

  assign dout = g_stage[DEPTH-1].q_reg;

endmodule

// File: rtl/pe0_twiddle_mul.sv
// Twiddle multiply ahead of the PE1 butterfly: v_out = v*w mod Q (sel=0)
// or v delayed (sel=1), with u/sel/valid aligned at a fixed latency of 4.
module pe0_twiddle_mul
  import pe0_twiddle_mul_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  sel,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] u,
  input  logic [DATA_WIDTH-1:0] v,
  input  logic [DATA_WIDTH-1:0] w,
  output logic                  valid_out,
  output logic                  sel_out,
  output logic [DATA_WIDTH-1:0] u_out,
  output logic [DATA_WIDTH-1:0] v_out
);

  localparam int LANE_W = $bits(lane_t);
  localparam int OUT_W  = DATA_WIDTH + 2;

  lane_t                 lane_in, lane_s3;
  logic [P_WIDTH-1:0]    p_next, p_reg;
  logic [OUT_W-1:0]      out_lane;

  // Stage 1 product.
  always_comb begin
    p_next = P_WIDTH'(v) * P_WIDTH'(w);
  end

  // Stage 1: register the full-width product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) p_reg <= '0;
    else if (en) p_reg <= p_next;
  end

  assign lane_in = '{valid: valid_in, sel: sel, u: u, v: v};

  // Side-band stages 1..3, aligned with the remainder register.
  pe0_twiddle_mul_delay #(.WIDTH(LANE_W), .DEPTH(3)) u_lane_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (lane_in),
    .dout (lane_s3)
  );

  barrett_reduce u_barrett (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .p          (p_reg),
    .bypass     (lane_s3.sel),
    .bypass_val (lane_s3.v),
    .res        (v_out)
  );

  // Stage 4 for valid/sel/u, alongside the reduction output register.
  pe0_twiddle_mul_delay #(.WIDTH(OUT_W), .DEPTH(1)) u_out_delay (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  ({lane_s3.valid, lane_s3.sel, lane_s3.u}),
    .dout (out_lane)
  );

  assign valid_out = out_lane[OUT_W-1];
  assign sel_out   = out_lane[OUT_W-2];
  assign u_out     = out_lane[DATA_WIDTH-1:0];

endmodule

// File: tb/tb_pe0_twiddle_mul.sv
// Self-checking bench for pe0_twiddle_mul: directed table, stall, async
// reset mid-stream and a random stream against a (v*w)%Q model.
module tb_pe0_twiddle_mul;
  import pe0_twiddle_mul_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic        sel = 1'b0;
  logic        valid_in = 1'b0;
  logic [11:0] u = '0, v = '0, w = '0;
  logic        valid_out, sel_out;
  logic [11:0] u_out, v_out;

  pe0_twiddle_mul dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .valid_in(valid_in),
    .u(u), .v(v), .w(w),
    .valid_out(valid_out), .sel_out(sel_out), .u_out(u_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        sel;
    logic [11:0] u;
    logic [11:0] v;
  } exp_t;

  typedef struct {
    logic        sel;
    logic [11:0] u;
    logic [11:0] v;
    logic [11:0] w;
    logic [11:0] exp_v;
  } vec_t;

  exp_t pipe [4];
  vec_t vecs [13];
  int   checks = 0;
  int   errors = 0;
  bit   verbose = 1'b1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [11:0] modq(input logic [11:0] a, input logic [11:0] b);
    int prod;
    prod = int'(a) * int'(b);
    return 12'(prod % Q);
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) pipe[i] = '{1'b0, 1'b0, 12'd0, 12'd0};
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, int'(valid_out), 0);
    check({tag, "_sel"},   int'(sel_out),   0);
    check({tag, "_u"},     int'(u_out),     0);
    check({tag, "_v"},     int'(v_out),     0);
  endtask

  task automatic compare_out();
    check("valid_out", int'(valid_out), int'(pipe[3].valid));
    if (pipe[3].valid) begin
      check("sel_out", int'(sel_out), int'(pipe[3].sel));
      check("u_out",   int'(u_out),   int'(pipe[3].u));
      check("v_out",   int'(v_out),   int'(pipe[3].v));
      if (verbose)
        $display("out t=%0t sel=%0d u=%0d v=%0d (expect sel=%0d u=%0d v=%0d)",
                 $time, sel_out, u_out, v_out, pipe[3].sel, pipe[3].u, pipe[3].v);
    end
  endtask

  // One clock: drive inputs, advance the model on enabled edges, compare.
  task automatic cycle(input logic e, input logic vi, input logic s,
                       input logic [11:0] uu, input logic [11:0] vv,
                       input logic [11:0] ww, input logic [11:0] ev);
    en = e; valid_in = vi; sel = s; u = uu; v = vv; w = ww;
    @(posedge clk);
    if (rst && e) begin
      for (int i = 3; i > 0; i--) pipe[i] = pipe[i-1];
      pipe[0] = '{vi, s, uu, ev};
    end
    #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 12'd0);
  endtask

  initial begin
    // Directed vectors: {sel, u, v, w, expected v_out}
    vecs[0]  = '{1'b0, 12'd100,  12'd2,    12'd17,   12'd34};
    vecs[1]  = '{1'b0, 12'd7,    12'd3328, 12'd3328, 12'd1};
    vecs[2]  = '{1'b0, 12'd8,    12'd3328, 12'd1,    12'd3328};
    vecs[3]  = '{1'b0, 12'd9,    12'd0,    12'd3000, 12'd0};
    vecs[4]  = '{1'b0, 12'd10,   12'd4095, 12'd4095, 12'd852};
    vecs[5]  = '{1'b1, 12'd5,    12'd1234, 12'd999,  12'd1234};
    vecs[6]  = '{1'b0, 12'd11,   12'd1234, 12'd999,  12'd1036};
    vecs[7]  = '{1'b1, 12'd12,   12'd4095, 12'd7,    12'd4095};
    vecs[8]  = '{1'b0, 12'd13,   12'd1,    12'd1,    12'd1};
    vecs[9]  = '{1'b1, 12'd15,   12'd0,    12'd0,    12'd0};
    vecs[10] = '{1'b0, 12'd14,   12'd3329, 12'd5,    12'd0};
    vecs[11] = '{1'b1, 12'd4095, 12'd2000, 12'd2,    12'd2000};
    vecs[12] = '{1'b0, 12'd4095, 12'd1665, 12'd2,    12'd1};

    clear_model();

    // Reset state, including across clock edges and before first enable.
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 check_zero("reset_held");
    rst = 1'b1;
    #1 check_zero("reset_released");

    // Single forward sample, then idle to see exactly one valid output.
    cycle(1'b1, 1'b1, 1'b0, 12'd100, 12'd2, 12'd17, 12'd34);
    idle(5);

    // Table applied back-to-back (mixed sel on consecutive cycles).
    for (int i = 0; i < 13; i++)
      cycle(1'b1, 1'b1, vecs[i].sel, vecs[i].u, vecs[i].v, vecs[i].w, vecs[i].exp_v);
    idle(4);

    // Stall: 8 samples, en dropped for 3 cycles with garbage on the inputs.
    for (int k = 0; k < 8; k++) begin
      logic [11:0] sv, sw;
      logic        ss;
      if (k == 4)
        for (int j = 0; j < 3; j++)
          cycle(1'b0, 1'b1, 1'b1, 12'd777, 12'd777, 12'd777, 12'd0);
      sv = 12'(3000 + 37 * k);
      sw = 12'(11 + 5 * k);
      ss = (k % 3 == 0);
      cycle(1'b1, 1'b1, ss, 12'(200 + k), sv, sw, ss ? sv : modq(sv, sw));
    end
    idle(4);

    // Async reset with samples in flight: outputs clear between edges.
    for (int k = 0; k < 5; k++)
      cycle(1'b1, 1'b1, 1'b0, 12'(50 + k), 12'(900 + k), 12'd3, modq(12'(900 + k), 12'd3));
    rst = 1'b0;
    #1 check_zero("async_reset");
    clear_model();
    @(posedge clk);
    #1 check_zero("async_reset_edge");
    #3 rst = 1'b1;
    #1 check_zero("async_release");
    idle(6);

    // Random stream at one sample per cycle, random mode per sample.
    verbose = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      logic [11:0] rv, rw, ru;
      logic        rs;
      rv = 12'($urandom_range(4095));
      rw = 12'($urandom_range(4095));
      ru = 12'($urandom_range(4095));
      rs = 1'($urandom_range(1));
      cycle(1'b1, 1'b1, rs, ru, rv, rw, rs ? rv : modq(rv, rw));
    end
    verbose = 1'b1;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
